// File: rtl/mic_ctl.sv
// I2S capture controller: derives MCLK/SCK/LRCK from a free-running counter and
// deserialises stereo 16-bit samples into a valid/ready held output pair.
module mic_ctl #(
  parameter logic [3:0] SAMPLE_PHASE = 4'hB
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               audio_sdout,
  input  logic               ready,
  output logic               audio_mclk,
  output logic               audio_lrck,
  output logic               audio_sck,
  output logic signed [15:0] audio_left,
  output logic signed [15:0] audio_right,
  output logic               valid,
  output logic               overrun
);

  localparam int DATA_W = 16;

  logic [8:0]               cnt;
  logic [8:0]               cnt_nxt;
  logic                     sync_p0;
  logic                     sync_p1;
  logic signed [DATA_W-1:0] shift_p2;
  logic signed [DATA_W-1:0] shift_nxt;
  logic signed [DATA_W-1:0] hold_p2;
  logic                     primed;
  logic                     capture;
  logic                     slot0;
  logic                     complete;

  function automatic logic signed [DATA_W-1:0] shift_in(
    input logic signed [DATA_W-1:0] word,
    input logic                     din
  );
    return {word[DATA_W-2:0], din};
  endfunction

  assign cnt_nxt   = cnt + 9'd1;
  assign capture   = (cnt[3:0] == SAMPLE_PHASE);
  assign slot0     = (cnt[7:4] == 4'd0);
  assign complete  = capture & slot0 & ~cnt[8];
  assign shift_nxt = shift_in(shift_p2, sync_p1);

  // Clock generation: outputs register the next count so each equals its cnt bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      audio_mclk <= 1'b0;
      audio_sck  <= 1'b0;
      audio_lrck <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      audio_mclk <= cnt_nxt[1];
      audio_sck  <= cnt_nxt[3];
      audio_lrck <= cnt_nxt[8];
    end
  end

  // Stage p0/p1: two-flop synchronizer for the asynchronous ADC data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= audio_sdout;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: deserialiser; slot 0 of the right half closes the left word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_p2 <= '0;
      hold_p2  <= '0;
    end else if (capture) begin
      shift_p2 <= shift_nxt;
      if (slot0 && cnt[8]) hold_p2 <= shift_nxt;
    end
  end

  // Output handshake; the first left-half completion after reset has no right word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      primed      <= 1'b0;
      audio_left  <= '0;
      audio_right <= '0;
      valid       <= 1'b0;
      overrun     <= 1'b0;
    end else if (complete) begin
      if (!primed) begin
        primed <= 1'b1;
      end else begin
        audio_left  <= hold_p2;
        audio_right <= shift_nxt;
        valid       <= 1'b1;
        if (valid && !ready) overrun <= 1'b1;
      end
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mic_ctl.sv
// Bench for mic_ctl: an I2S transmitter model feeds stereo words; a vector table
// and a scoreboard of expected pairs check the captured outputs and handshake.
module tb_mic_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        audio_sdout = 1'b0;
  logic        ready = 1'b0;
  logic        audio_mclk, audio_lrck, audio_sck;
  logic [15:0] audio_left, audio_right;
  logic        valid, overrun;

  int tests = 0;
  int fails = 0;

  logic [15:0] tb_l = 16'h0000;
  logic [15:0] tb_r = 16'h0000;
  logic [8:0]  tb_cnt;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
  } pair_t;
  pair_t sb[$];

  typedef struct {
    string       name;
    logic [15:0] l;
    logic [15:0] r;
    logic [15:0] exp_l;
    logic [15:0] exp_r;
  } vec_t;

  mic_ctl dut (
    .clk        (clk),
    .rst        (rst),
    .audio_sdout(audio_sdout),
    .ready      (ready),
    .audio_mclk (audio_mclk),
    .audio_lrck (audio_lrck),
    .audio_sck  (audio_sck),
    .audio_left (audio_left),
    .audio_right(audio_right),
    .valid      (valid),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  // Independent I2S frame timebase: 16 clk per bit slot, 256 clk per channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tb_cnt <= '0;
    else     tb_cnt <= tb_cnt + 9'd1;
  end

  function automatic logic i2s_bit(input logic [8:0] c, input logic [15:0] l,
                                   input logic [15:0] r);
    int s;
    s = int'(c[7:4]);
    if (s == 0) return c[8] ? l[0] : r[0];
    return c[8] ? r[16 - s] : l[16 - s];
  endfunction

  always @(negedge clk) audio_sdout = i2s_bit(tb_cnt, tb_l, tb_r);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string name);
    pair_t p;
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      p = sb.pop_front();
      chk({name, "_pair"}, {audio_left, audio_right}, {p.l, p.r});
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_ctl", {27'd0, valid, overrun, audio_mclk, audio_sck, audio_lrck}, 32'd0);
    chk("reset_data", {audio_left, audio_right}, 32'd0);
    rst = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (valid) break;
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  vec_t vecs[6];

  initial begin
    int n;
    int bad;
    logic [15:0] hl, hr;

    vecs[0] = '{"i2s_8001_7ffe", 16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE};
    vecs[1] = '{"stuck_one",     16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    vecs[2] = '{"stuck_zero",    16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vecs[3] = '{"i2s_1234_abcd", 16'h1234, 16'hABCD, 16'h1234, 16'hABCD};
    vecs[4] = '{"i2s_extremes",  16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF};
    vecs[5] = '{"i2s_a5c3_3c5a", 16'hA5C3, 16'h3C5A, 16'hA5C3, 16'h3C5A};

    // Table vectors: first pair latency, values, and one-cycle valid with ready=1
    foreach (vecs[i]) begin
      tb_l  = vecs[i].l;
      tb_r  = vecs[i].r;
      ready = 1'b1;
      do_reset();
      sb.push_back('{vecs[i].exp_l, vecs[i].exp_r});
      wait_valid(n);
      chk({vecs[i].name, "_latency"}, n, 524);
      sb_check(vecs[i].name);
      chk({vecs[i].name, "_overrun"}, {31'd0, overrun}, 32'd0);
      run_cycles(1);
      chk({vecs[i].name, "_valid_drop"}, {31'd0, valid}, 32'd0);
    end

    // Generated clock periods after release
    begin
      int tm, ts, tl, bm, bs, bl, lm, ls, ll;
      logic pm, ps, pl;
      tm = 0; ts = 0; tl = 0; bm = 0; bs = 0; bl = 0; lm = 0; ls = 0; ll = 0;
      pm = 1'b0; ps = 1'b0; pl = 1'b0;
      do_reset();
      for (int i = 1; i <= 1100; i++) begin
        @(posedge clk); #1;
        if (audio_mclk !== pm) begin
          if (i - lm != 2) bm++;
          lm = i; pm = audio_mclk; tm++;
        end
        if (audio_sck !== ps) begin
          if (i - ls != 8) bs++;
          ls = i; ps = audio_sck; ts++;
        end
        if (audio_lrck !== pl) begin
          if (i - ll != 256) bl++;
          ll = i; pl = audio_lrck; tl++;
        end
      end
      chk("mclk_period", bm, 0);
      chk("mclk_toggles", tm, 550);
      chk("sck_period", bs, 0);
      chk("sck_toggles", ts, 137);
      chk("lrck_period", bl, 0);
      chk("lrck_toggles", tl, 4);
    end

    // Ready held low across three frames: valid sticks, overrun at second completion
    tb_l = 16'h1234; tb_r = 16'hABCD; ready = 1'b0;
    do_reset();
    sb.push_back('{16'h1234, 16'hABCD});
    wait_valid(n);
    chk("hold_latency", n, 524);
    sb_check("hold_first");
    hl = audio_left; hr = audio_right;
    bad = 0;
    repeat (511) begin
      @(posedge clk); #1;
      if (!valid || overrun || audio_left !== hl || audio_right !== hr) bad++;
    end
    chk("hold_stable", bad, 0);
    sb.push_back('{16'h1234, 16'hABCD});
    run_cycles(1);
    chk("hold_overrun_set", {30'd0, valid, overrun}, 32'd3);
    sb_check("hold_second");
    tb_l = 16'h5A5A; tb_r = 16'hC3C3;
    sb.push_back('{16'h5A5A, 16'hC3C3});
    run_cycles(512);
    chk("hold_third_ctl", {30'd0, valid, overrun}, 32'd3);
    sb_check("hold_overwrite");

    // Ready rising exactly in a completion cycle: accept old, load new, no overrun
    tb_l = 16'h1111; tb_r = 16'h2222; ready = 1'b0;
    do_reset();
    sb.push_back('{16'h1111, 16'h2222});
    wait_valid(n);
    chk("coincide_latency", n, 524);
    sb_check("coincide_first");
    tb_l = 16'h3333; tb_r = 16'h4444;
    run_cycles(511);
    ready = 1'b1;
    sb.push_back('{16'h3333, 16'h4444});
    run_cycles(1);
    chk("coincide_ctl", {30'd0, valid, overrun}, 32'd2);
    sb_check("coincide_new");
    run_cycles(1);
    chk("coincide_drop", {31'd0, valid}, 32'd0);
    ready = 1'b0;

    // Asynchronous reset at cnt=0x150 with a pair pending and overrun set
    tb_l = 16'h0F0F; tb_r = 16'hF0F0; ready = 1'b0;
    do_reset();
    wait_valid(n);
    run_cycles(512);
    n = 0;
    while (tb_cnt != 9'h150 && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    chk("midreset_pre_overrun", {30'd0, valid, overrun}, 32'd3);
    rst = 1'b1;
    #1;
    chk("midreset_ctl", {27'd0, valid, overrun, audio_mclk, audio_sck, audio_lrck}, 32'd0);
    chk("midreset_data", {audio_left, audio_right}, 32'd0);
    tb_l = 16'h7E57; tb_r = 16'h0BAD;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.push_back('{16'h7E57, 16'h0BAD});
    wait_valid(n);
    chk("midreset_latency", n, 524);
    sb_check("midreset_fresh");
    chk("midreset_overrun", {31'd0, overrun}, 32'd0);
    chk("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
